// File: rtl/snoopy_score_tracker_if.sv
// Bus between the Snoopy horizontal FSM side and the score tracker.
// HIGH_SCORE_EN adds the best_score signal to both modports.
`default_nettype none

interface snoopy_score_tracker_if;
  logic [7:0] snoopy_x;
  logic       restart;
  logic [3:0] score;
  logic       score_pulse;
  logic       win;
  logic [6:0] HEX0;
`ifdef HIGH_SCORE_EN
  logic [3:0] best_score;

  modport master (
    output snoopy_x, restart,
    input  score, score_pulse, win, HEX0, best_score
  );

  modport slave (
    input  snoopy_x, restart,
    output score, score_pulse, win, HEX0, best_score
  );
`else
  modport master (
    output snoopy_x, restart,
    input  score, score_pulse, win, HEX0
  );

  modport slave (
    input  snoopy_x, restart,
    output score, score_pulse, win, HEX0
  );
`endif
endinterface

`default_nettype wire

// File: rtl/snoopy_score_tracker.sv
// Awards one point per rightward checkpoint crossing and flags a win at the goal column.
// Optional feature macro: HIGH_SCORE_EN (adds best_score, cleared only by reset).
`default_nettype none

module snoopy_score_tracker #(
  parameter int         NUM_OBST = 6,
  parameter logic [7:0] OBST0    = 8'd39,
  parameter logic [7:0] OBST1    = 8'd60,
  parameter logic [7:0] OBST2    = 8'd80,
  parameter logic [7:0] OBST3    = 8'd110,
  parameter logic [7:0] OBST4    = 8'd126,
  parameter logic [7:0] OBST5    = 8'd153,
  parameter logic [7:0] WIN_X    = 8'd155
) (
  input  logic                   clock,
  input  logic                   reset,
  snoopy_score_tracker_if.slave  bus
);

  localparam logic [3:0] NUM_OBST_W = 4'(NUM_OBST);
  localparam logic [6:0] SEG_ZERO   = 7'b1000000;

  typedef enum logic [0:0] {
    S_PLAY = 1'b0,
    S_WIN  = 1'b1
  } state_t;

  state_t     state_q,       state_d;
  logic [3:0] next_idx_q,    next_idx_d;
  logic [3:0] score_q,       score_d;
  logic       score_pulse_q, score_pulse_d;
  logic       win_q,         win_d;
  logic [6:0] hex0_q,        hex0_d;
`ifdef HIGH_SCORE_EN
  logic [3:0] best_score_q,  best_score_d;
`endif

  logic [7:0] cur_obst;
  logic       cross_hit;
  logic       goal_hit;

  // Checkpoint columns beyond the sixth reuse the last one.
  function automatic logic [7:0] obst_at(input logic [3:0] idx);
    logic [7:0] col;
    case (idx)
      4'd0:    col = OBST0;
      4'd1:    col = OBST1;
      4'd2:    col = OBST2;
      4'd3:    col = OBST3;
      4'd4:    col = OBST4;
      default: col = OBST5;
    endcase
    return col;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] val);
    logic [6:0] seg;
    case (val)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  assign cur_obst  = obst_at(next_idx_q);
  assign cross_hit = (next_idx_q < NUM_OBST_W) && (bus.snoopy_x > cur_obst);
  // Win looks at the registered index, so it trails the final increment by a cycle.
  assign goal_hit  = (next_idx_q == NUM_OBST_W) && (bus.snoopy_x >= WIN_X);

  always_comb begin
    state_d       = state_q;
    next_idx_d    = next_idx_q;
    score_d       = score_q;
    win_d         = win_q;
    score_pulse_d = 1'b0;
`ifdef HIGH_SCORE_EN
    best_score_d  = best_score_q;
`endif

    if (bus.restart) begin
      state_d    = S_PLAY;
      next_idx_d = 4'd0;
      score_d    = 4'd0;
      win_d      = 1'b0;
    end else if (state_q == S_PLAY) begin
      if (cross_hit) begin
        score_d       = score_q + 4'd1;
        next_idx_d    = next_idx_q + 4'd1;
        score_pulse_d = 1'b1;
`ifdef HIGH_SCORE_EN
        if (score_d > best_score_q) begin
          best_score_d = score_d;
        end
`endif
      end
      if (goal_hit) begin
        state_d = S_WIN;
        win_d   = 1'b1;
      end
    end

    hex0_d = seg7(score_d);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= S_PLAY;
      next_idx_q    <= 4'd0;
      score_q       <= 4'd0;
      score_pulse_q <= 1'b0;
      win_q         <= 1'b0;
      hex0_q        <= SEG_ZERO;
`ifdef HIGH_SCORE_EN
      best_score_q  <= 4'd0;
`endif
    end else begin
      state_q       <= state_d;
      next_idx_q    <= next_idx_d;
      score_q       <= score_d;
      score_pulse_q <= score_pulse_d;
      win_q         <= win_d;
      hex0_q        <= hex0_d;
`ifdef HIGH_SCORE_EN
      best_score_q  <= best_score_d;
`endif
    end
  end

  assign bus.score       = score_q;
  assign bus.score_pulse = score_pulse_q;
  assign bus.win         = win_q;
  assign bus.HEX0        = hex0_q;
`ifdef HIGH_SCORE_EN
  assign bus.best_score  = best_score_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_snoopy_score_tracker.sv
// Randomized and directed checks of snoopy_score_tracker against a round-level model.
`default_nettype none

module tb_snoopy_score_tracker;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  snoopy_score_tracker_if sif ();

  snoopy_score_tracker dut (
    .clock (clock),
    .reset (reset),
    .bus   (sif)
  );

  int assertions = 0;
  int failures   = 0;

  int         obst [6] = '{39, 60, 80, 110, 126, 153};
  int         goal_x   = 155;
  logic [6:0] seg  [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Round model: how many checkpoints are behind Snoopy, and whether the goal was reached.
  int m_cleared = 0;
  bit m_won     = 1'b0;
  bit m_pulse   = 1'b0;
  int m_best    = 0;

  logic [13:0] exp_v;
  logic [13:0] got_v;

  task automatic apply_reset();
    reset        = 1'b0;
    sif.snoopy_x = 8'd0;
    sif.restart  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset     = 1'b1;
    m_cleared = 0;
    m_won     = 1'b0;
    m_pulse   = 1'b0;
    m_best    = 0;
  endtask

  task automatic cycle(input int x, input bit rs);
    sif.snoopy_x = 8'(x);
    sif.restart  = rs;
    @(posedge clock);
    #1;
    m_pulse = 1'b0;
    if (rs) begin
      m_cleared = 0;
      m_won     = 1'b0;
    end else if (!m_won) begin
      if (m_cleared == 6 && x >= goal_x) begin
        m_won = 1'b1;
      end else if (m_cleared < 6 && x > obst[m_cleared]) begin
        m_cleared++;
        m_pulse = 1'b1;
        if (m_cleared > m_best) m_best = m_cleared;
      end
    end
    exp_v = {4'(m_cleared), m_pulse, m_won, seg[m_cleared]};
    got_v = {sif.score, sif.score_pulse, sif.win, sif.HEX0};
  endtask

  task automatic test_reset();
    int pulses = 0;
    apply_reset();
    assertions++;
    if ({sif.score, sif.score_pulse, sif.win, sif.HEX0} !== {4'd0, 1'b0, 1'b0, 7'b1000000}) begin
      failures++;
      $display("FAIL reset_state got %b required %b",
               {sif.score, sif.score_pulse, sif.win, sif.HEX0}, {4'd0, 1'b0, 1'b0, 7'b1000000});
    end
    for (int i = 0; i < 10; i++) begin
      cycle(15, 1'b0);
      if (sif.score_pulse) pulses++;
      assertions++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL idle_x15 cyc=%0d got %b required %b", i, got_v, exp_v);
      end
    end
    assertions++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL idle_no_pulse got %0d pulses required 0", pulses);
    end
  endtask

  task automatic test_single_cross();
    apply_reset();
    for (int x = 15; x <= 40; x++) begin
      cycle(x, 1'b0);
      assertions++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL single_cross x=%0d got %b required %b", x, got_v, exp_v);
      end
      if (x == 40) begin
        assertions++;
        if ({sif.score_pulse, sif.score, sif.HEX0} !== {1'b1, 4'd1, 7'b1111001}) begin
          failures++;
          $display("FAIL first_point got %b required %b",
                   {sif.score_pulse, sif.score, sif.HEX0}, {1'b1, 4'd1, 7'b1111001});
        end
      end
    end
  endtask

  task automatic test_recross();
    int pulses = 0;
    int path [$];
    apply_reset();
    for (int x = 15; x <= 45; x++) path.push_back(x);
    for (int x = 44; x >= 30; x--) path.push_back(x);
    for (int x = 31; x <= 45; x++) path.push_back(x);
    foreach (path[i]) begin
      cycle(path[i], 1'b0);
      if (sif.score_pulse) pulses++;
      assertions++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL recross x=%0d got %b required %b", path[i], got_v, exp_v);
      end
    end
    assertions++;
    if (pulses != 1 || sif.score !== 4'd1) begin
      failures++;
      $display("FAIL recross_total got pulses=%0d score=%0d required pulses=1 score=1", pulses, sif.score);
    end
  endtask

  task automatic test_full_run();
    int pulse_x [$];
    int want    [6] = '{40, 61, 81, 111, 127, 154};
    apply_reset();
    for (int x = 15; x <= 155; x++) begin
      cycle(x, 1'b0);
      if (sif.score_pulse) pulse_x.push_back(x);
      assertions++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL full_run x=%0d got %b required %b", x, got_v, exp_v);
      end
    end
    assertions++;
    if (pulse_x.size() != 6) begin
      failures++;
      $display("FAIL full_run_pulses got %0d required 6", pulse_x.size());
    end else begin
      foreach (want[i]) begin
        assertions++;
        if (pulse_x[i] != want[i]) begin
          failures++;
          $display("FAIL pulse_pos idx=%0d got x=%0d required x=%0d", i, pulse_x[i], want[i]);
        end
      end
    end
    assertions++;
    if ({sif.score, sif.win, sif.HEX0} !== {4'd6, 1'b1, 7'b0000010}) begin
      failures++;
      $display("FAIL goal_state got %b required %b", {sif.score, sif.win, sif.HEX0}, {4'd6, 1'b1, 7'b0000010});
    end
    repeat (5) begin
      cycle(0, 1'b0);
      assertions++;
      if ({sif.score, sif.score_pulse, sif.win} !== {4'd6, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL win_hold got %b required %b", {sif.score, sif.score_pulse, sif.win}, {4'd6, 1'b0, 1'b1});
      end
    end
  endtask

  task automatic test_jump_restart();
    apply_reset();
    cycle(15, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(200, i == 2);
      assertions++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL jump cyc=%0d got %b required %b", i, got_v, exp_v);
      end
    end
    assertions++;
    if ({sif.score, sif.score_pulse, sif.win} !== 6'b0) begin
      failures++;
      $display("FAIL restart_priority got %b required 000000", {sif.score, sif.score_pulse, sif.win});
    end
    repeat (3) begin
      cycle(200, 1'b1);
      assertions++;
      if ({sif.score, sif.score_pulse, sif.win, sif.HEX0} !== {6'b0, 7'b1000000}) begin
        failures++;
        $display("FAIL restart_held got %b required %b", {sif.score, sif.score_pulse, sif.win, sif.HEX0}, {6'b0, 7'b1000000});
      end
    end
    for (int i = 0; i < 8; i++) begin
      cycle(200, 1'b0);
      assertions++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL jump_run cyc=%0d got %b required %b", i, got_v, exp_v);
      end
    end
    assertions++;
    if ({sif.score, sif.win} !== {4'd6, 1'b1}) begin
      failures++;
      $display("FAIL jump_win got %b required %b", {sif.score, sif.win}, {4'd6, 1'b1});
    end
  endtask

  task automatic test_random();
    int x = 0;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) x = int'($urandom_range(0, 255));
      else x = x + int'($urandom_range(0, 9)) - 3;
      if (x < 0) x = 0;
      if (x > 255) x = 255;
      cycle(x, $urandom_range(0, 49) == 0);
      assertions++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL random cyc=%0d x=%0d got %b required %b", i, x, got_v, exp_v);
      end
`ifdef HIGH_SCORE_EN
      assertions++;
      if (sif.best_score !== 4'(m_best)) begin
        failures++;
        $display("FAIL random_best cyc=%0d got %0d required %0d", i, sif.best_score, m_best);
      end
`endif
    end
  endtask

`ifdef HIGH_SCORE_EN
  task automatic test_best_score();
    apply_reset();
    for (int x = 0; x <= 115; x += 5) cycle(x, 1'b0);
    cycle(0, 1'b1);
    for (int x = 0; x <= 65; x += 5) cycle(x, 1'b0);
    assertions++;
    if ({sif.score, sif.best_score} !== {4'd2, 4'd4}) begin
      failures++;
      $display("FAIL best_keep got %b required %b", {sif.score, sif.best_score}, {4'd2, 4'd4});
    end
    apply_reset();
    assertions++;
    if (sif.best_score !== 4'd0) begin
      failures++;
      $display("FAIL best_reset got %0d required 0", sif.best_score);
    end
  endtask
`endif

  initial begin
    sif.snoopy_x = 8'd0;
    sif.restart  = 1'b0;
    test_reset();
    test_single_cross();
    test_recross();
    test_full_run();
    test_jump_restart();
`ifdef HIGH_SCORE_EN
    test_best_score();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
